// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: requester IDs,
// FSM state encoding and default bus widths.
package mem_port_arbiter_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 32;

  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_LDST  = 2'd1;
  localparam logic [1:0] REQ_STACK = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled for port use.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
);

  // Handshake: a requester raises req[i] with we/addr/wdata stable and holds
  // them until ack[i]; ack is a single-cycle pulse, rdata valid only then.
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    we;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       rdata;

  logic                mem_en;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata;

  logic                busy;
  logic [1:0]          gnt_id;

  modport master (
    input  req, we, addr, wdata, mem_rdata,
    output ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_id
  );

  modport slave (
    output req, we, addr, wdata, mem_rdata,
    input  ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_id
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Round-robin requester selection; the rotating priority pointer advances
// past the winner only when the grant is accepted.
module mem_port_arbiter_rr_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_accept,
  output logic [N_REQ-1:0] o_gnt,
  output logic [1:0]       o_gnt_idx,
  output logic             o_valid
);

  logic [1:0]       r_ptr;
  logic [N_REQ-1:0] w_gnt;
  logic [1:0]       w_idx;
  logic             w_valid;
  logic [2:0]       w_cand;

  // Walk the requesters starting at the pointer; first hit wins.
  always_comb begin
    w_gnt   = '0;
    w_idx   = REQ_FETCH;
    w_valid = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + 3'(k);
      if (w_cand >= 3'(N_REQ)) begin
        w_cand = w_cand - 3'(N_REQ);
      end
      if (!w_valid && i_req[w_cand[1:0]]) begin
        w_valid              = 1'b1;
        w_idx                = w_cand[1:0];
        w_gnt[w_cand[1:0]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= REQ_FETCH;
    end else if (i_accept && w_valid) begin
      r_ptr <= (w_idx == 2'(N_REQ - 1)) ? 2'd0 : w_idx + 2'd1;
    end
  end

  assign o_gnt     = w_gnt;
  assign o_gnt_idx = w_idx;
  assign o_valid   = w_valid;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between N_REQ requesters with
// round-robin arbitration and one transaction in flight at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus,
  output state_e              o_state
);

  localparam int CW = 2;

  state_e           r_state;
  state_e           w_next;
  logic             w_accept;
  logic             w_done;

  logic [N_REQ-1:0] w_gnt;
  logic [1:0]       w_gnt_idx;
  logic             w_gnt_valid;

  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_gnt_id;
  logic [N_REQ-1:0] r_gnt_oh;
  logic             r_mem_en;
  logic             r_mem_we;
  logic [AW-1:0]    r_mem_addr;
  logic [DW-1:0]    r_mem_wdata;

  mem_port_arbiter_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .i_req     (bus.req),
    .i_accept  (w_accept),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_valid   (w_gnt_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_accept = 1'b1;
          w_next   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // The memory-side registers double as the request latch: loading them at
  // the grant puts the access on the pins during the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_gnt_id    <= REQ_FETCH;
      r_gnt_oh    <= '0;
      r_cnt       <= '0;
    end else begin
      r_mem_en <= w_accept;
      r_mem_we <= w_accept & bus.we[w_gnt_idx];
      if (w_accept) begin
        r_mem_addr  <= bus.addr[w_gnt_idx*AW +: AW];
        r_mem_wdata <= bus.wdata[w_gnt_idx*DW +: DW];
        r_gnt_id    <= w_gnt_idx;
        r_gnt_oh    <= w_gnt;
      end
      if (r_state == ST_ACCESS) begin
        r_cnt <= CW'(MEM_LAT - 1);
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign bus.ack       = w_done ? r_gnt_oh : '0;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.gnt_id    = r_gnt_id;
  assign o_state       = r_state;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data memory between three requesters: instruction fetch, load/store (LD/ST) and the stack unit (call push / return pop).
- Round-robin arbitration with a multi-cycle access FSM; one transaction in flight at a time.
- Sits between the control/datapath requesters and the memory macro.

Parameters:
- N_REQ, 3, number of requesters (0=fetch, 1=ld/st, 2=stack); legal 2..4.
- AW, 8, memory address width.
- DW, 32, memory data width.
- MEM_LAT, 1, memory read latency in cycles from the enable cycle to valid mem_rdata; legal 1..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req  in  N_REQ  per-requester request; held until ack.
- we  in  N_REQ  per-requester write enable (1=write, 0=read); valid with req.
- addr  in  N_REQ*AW  packed addresses; requester i at [i*AW +: AW].
- wdata  in  N_REQ*DW  packed write data; requester i at [i*DW +: DW].
- ack  out  N_REQ  one-cycle completion pulse for the granted requester.
- rdata  out  DW  read data; valid only in the cycle ack is high for a read.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high whenever the FSM is not IDLE.
- gnt_id  out  2  index of the current or last granted requester.

Behaviour:
- Reset values: ack=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, gnt_id=0, state=IDLE, RR pointer=0 (requester 0 highest priority), latency counter=0.
- FSM states:
  - IDLE: if any req, pick winner by round-robin, latch its we/addr/wdata and id, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: exactly one cycle. mem_en=1, mem_we, mem_addr and mem_wdata are driven from the latched values. Load counter with MEM_LAT-1, then go to WAIT.
  - WAIT: decrement counter. When counter==0, ack[gnt_id]=1 for this cycle only and rdata=mem_rdata; then go to IDLE.
- Latency: request seen in IDLE at cycle T → mem_en at T+1 → ack at T+1+MEM_LAT. Writes use the same timing as reads.
- Throughput: one transaction per MEM_LAT+2 cycles; arbitration happens only in IDLE.
- Round-robin:
  - Search starts at the pointer and wraps modulo N_REQ.
  - After granting i, the pointer becomes (i+1) mod N_REQ.
  - The pointer changes only on a grant.
- mem_en, mem_we, mem_addr and mem_wdata are registered outputs. mem_addr and mem_wdata hold their last values outside ACCESS; mem_we=0 outside ACCESS.
- rdata is a combinational passthrough of mem_rdata; it is undefined except in a read ack cycle.
- Requester protocol: req, we, addr and wdata are held stable from assertion until ack.
  - Input changes after the IDLE sampling cycle are ignored (the values are latched).
  - Dropping req mid-transaction does not cancel it: the access completes and ack still pulses.
- A requester still asserting req in the cycle after its ack is treated as a new request, arbitrated normally.
- All requesters simultaneous from reset: grants go 0,1,2,0,1,2...
- No requester waits more than N_REQ-1 other transactions.
- reset mid-transaction: in the next cycle the FSM is in IDLE, mem_en=0, no ack for the aborted access, and the pointer is 0.
- Out-of-range MEM_LAT is a configuration error and is not checked in RTL.

Decomposition:
- Shared package holds:
  - requester IDs REQ_FETCH=0, REQ_LDST=1, REQ_STACK=2;
  - state encoding IDLE/ACCESS/WAIT;
  - default AW/DW constants.
- Sub-module rr_arbiter:
  - inputs: req vector, pointer register, grant-accept strobe;
  - outputs: one-hot grant and encoded index;
  - pointer update lives inside rr_arbiter.
- The FSM, latch registers and latency counter live in mem_port_arbiter.

Test Plan:
- Single read, MEM_LAT=1: req[1]=1, we=0, addr=0x10 at T0.
  - Required: mem_en=1 and mem_addr=0x10 at T1.
  - Required: ack=3'b010 with rdata=mem_rdata at T2; busy=0 at T3.
- Single write: req[2]=1, we=1, addr=0x3F, wdata=0xDEADBEEF.
  - Required: mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF at T1.
  - Required: ack[2] at T2; the model memory holds the value afterwards.
- Contention: req=3'b111 held continuously from reset.
  - Required: gnt_id sequence 0,1,2,0,1,2.
  - Required: each ack is spaced 3 cycles apart and no requester is starved.
- Latency parameter: MEM_LAT=3, single read.
  - Required: mem_en is high exactly one cycle at T1 and ack is at T4.
- Abort paths:
  - req[0] dropped at T1: ack[0] still pulses at T2.
  - reset at T1 of a transaction: at T2 mem_en=0 and busy=0, with no ack ever issued; the pointer is 0, so the next simultaneous grant goes to requester 0.
- Pointer rotation: grant requester 2, then assert req=3'b011.
  - Required: requester 0 is granted first (wrap-around), then requester 1.
